mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory between the fetch path (IF, read-only) and the load/store path (LS, read/write, driven by the control unit's MemRW).
- Sequences each access through a registered FSM and handles variable-latency memory.
- Raises a stall to the PC/pipeline while a data access is pending.
- Sits between the datapath (PC, ALU address, register rs2 data) and the memory macro.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_timeout.sv | 28 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BUSY_IF = 2'b01;
    localparam logic [1:0] ST_BUSY_LS = 2'b10;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_arb_timeout.sv
// Per-access wait counter; expired_o flags the last allowed wait cycle.
module mem_arb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned MAX_LS_BURST = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [3:0] MAX_B = 4'(MAX_LS_BURST);

    logic [1:0]        state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic              launch_if, launch_ls, busy, finish, done, expired, owner;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, ls_rdata_q;
    logic              if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q, err_q;

    assign busy   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_LS);
    assign owner  = (state_q == ST_BUSY_LS) ? OWN_LS : OWN_IF;
    assign done   = busy && mem_ready;
    assign finish = busy && (mem_ready || expired);

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        launch_if = 1'b0;
        launch_ls = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ls_req && (burst_q < MAX_B || !if_req)) begin
                    state_d   = ST_BUSY_LS;
                    burst_d   = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
                    launch_ls = 1'b1;
                end else if (if_req) begin
                    state_d   = ST_BUSY_IF;
                    burst_d   = '0;
                    launch_if = 1'b1;
                end
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (finish) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (launch_if | launch_ls),
        .en_i      (busy),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            if_gnt_q    <= launch_if;
            ls_gnt_q    <= launch_ls;
            if_rvalid_q <= finish && (owner == OWN_IF);
            ls_rvalid_q <= finish && (owner == OWN_LS);
            err_q       <= finish && !mem_ready;
            if (launch_if || launch_ls) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= launch_ls && ls_we;
                mem_addr_q  <= launch_ls ? ls_addr : if_addr;
                mem_wdata_q <= launch_ls ? ls_wdata : '0;
            end else if (finish) begin
                mem_req_q <= 1'b0;
            end
            // Stores complete without touching the load data register.
            if (done && owner == OWN_IF) if_rdata_q <= mem_rdata;
            if (done && owner == OWN_LS && !mem_we_q) ls_rdata_q <= mem_rdata;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err_o     = err_q;
    assign stall_o   = ls_req | (state_q == ST_BUSY_LS) | ls_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;
    localparam int TO   = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 0, ls_req = 0, ls_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, stall_o, err_o;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    int n_checks = 0, n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_BURST(MAXB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: one outstanding access record plus the output pulses due next cycle.
    bit          a_act, a_ls, a_we;
    logic [31:0] a_addr, a_wdata;
    int          a_wait, lsrun;
    bit          e_ifg, e_lsg, e_ifv, e_lsv, e_err;
    logic [31:0] e_ifd, e_lsd;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_act = 0; a_ls = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wait = 0; lsrun = 0;
            e_ifg = 0; e_lsg = 0; e_ifv = 0; e_lsv = 0; e_err = 0; e_ifd = 0; e_lsd = 0;
        end else begin
            chk("mdl mem_req", {31'd0, mem_req}, {31'd0, a_act});
            if (a_act) begin
                chk("mdl mem_we", {31'd0, mem_we}, {31'd0, a_we});
                chk("mdl mem_addr", mem_addr, a_addr);
                if (a_ls) chk("mdl mem_wdata", mem_wdata, a_wdata);
            end
            chk("mdl if_gnt", {31'd0, if_gnt}, {31'd0, e_ifg});
            chk("mdl ls_gnt", {31'd0, ls_gnt}, {31'd0, e_lsg});
            chk("mdl if_rvalid", {31'd0, if_rvalid}, {31'd0, e_ifv});
            chk("mdl ls_rvalid", {31'd0, ls_rvalid}, {31'd0, e_lsv});
            chk("mdl if_rdata", if_rdata, e_ifd);
            chk("mdl ls_rdata", ls_rdata, e_lsd);
            chk("mdl err_o", {31'd0, err_o}, {31'd0, e_err});
            chk("mdl stall_o", {31'd0, stall_o}, {31'd0, ls_req | (a_act & a_ls) | e_lsv});
            e_ifg = 0; e_lsg = 0; e_ifv = 0; e_lsv = 0; e_err = 0;
            if (a_act) begin
                if (mem_ready) begin
                    a_act = 0;
                    if (a_ls) begin
                        e_lsv = 1;
                        if (!a_we) e_lsd = mem_rdata;
                    end else begin
                        e_ifv = 1;
                        e_ifd = mem_rdata;
                    end
                end else begin
                    a_wait++;
                    if (TO_EN && a_wait >= TO) begin
                        a_act = 0;
                        e_err = 1;
                        if (a_ls) e_lsv = 1; else e_ifv = 1;
                    end
                end
            end else if (ls_req && (lsrun < MAXB || !if_req)) begin
                a_act = 1; a_ls = 1; a_we = ls_we; a_addr = ls_addr; a_wdata = ls_wdata;
                a_wait = 0; lsrun++; e_lsg = 1;
            end else if (if_req) begin
                a_act = 1; a_ls = 0; a_we = 0; a_addr = if_addr; a_wdata = 0;
                a_wait = 0; lsrun = 0; e_ifg = 1;
            end
        end
    end

    task automatic drain();
        if_req = 0; ls_req = 0; mem_ready = 1;
        repeat (3) step();
        mem_ready = 0;
        step();
    endtask

    initial begin
        bit seq[6];
        int ng, cnt;
        #23 rst_n = 1'b1;
        step();
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        chk("reset rdata", if_rdata | ls_rdata, 32'd0);

        // zero-wait fetch
        if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h00500093;
        step();
        chk("t1 if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("t1 mem_addr", mem_addr, 32'h100);
        chk("t1 mem_we", {31'd0, mem_we}, 32'd0);
        if_req = 0;
        step();
        chk("t1 if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1 if_rdata", if_rdata, 32'h00500093);
        chk("t1 mem_req off", {31'd0, mem_req}, 32'd0);
        mem_ready = 0;
        step();

        // burst limit with both requesters held
        if_req = 1; ls_req = 1; ls_we = 0; ls_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h11111111;
        ng = 0;
        for (int i = 0; i < 40 && ng < 6; i++) begin
            step();
            if (if_gnt) begin seq[ng] = 0; ng++; end
            else if (ls_gnt) begin seq[ng] = 1; ng++; end
        end
        chk("t3 grant count", ng, 6);
        for (int i = 0; i < 6; i++) chk("t3 grant owner", {31'd0, seq[i]}, (i == 4) ? 32'd0 : 32'd1);
        drain();
        chk("t3 ls_rdata", ls_rdata, 32'h11111111);

        // store with two wait cycles
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; mem_rdata = 32'hBAD0BAD0;
        #1 chk("t2 stall req", {31'd0, stall_o}, 32'd1);
        step();
        chk("t2 ls_gnt", {31'd0, ls_gnt}, 32'd1);
        ls_req = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2 mem_req", {31'd0, mem_req}, 32'd1);
            chk("t2 mem_we", {31'd0, mem_we}, 32'd1);
            chk("t2 mem_addr", mem_addr, 32'h2000);
            chk("t2 mem_wdata", mem_wdata, 32'hDEADBEEF);
            #1 chk("t2 stall busy", {31'd0, stall_o}, 32'd1);
            if (i == 2) mem_ready = 1;
            step();
        end
        chk("t2 ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("t2 stall ack", {31'd0, stall_o}, 32'd1);
        chk("t2 ls_rdata kept", ls_rdata, 32'h11111111);
        mem_ready = 0;
        step();
        chk("t2 stall off", {31'd0, stall_o}, 32'd0);

        // mem_ready while idle
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6 idle rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            chk("t6 idle mem_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ready = 0;

        // reset during a load
        ls_req = 1; ls_we = 0; ls_addr = 32'h3000;
        step();
        chk("t4 ls_gnt", {31'd0, ls_gnt}, 32'd1);
        ls_req = 0;
        step();
        #2 rst_n = 0;
        #1;
        chk("t4 mem_req", {31'd0, mem_req}, 32'd0);
        chk("t4 outs", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, stall_o, err_o, mem_we}, 32'd0);
        chk("t4 data", if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
        #3 rst_n = 1;
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4 no rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        end
        mem_ready = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        ls_req = 1; ls_we = 0; ls_addr = 32'h44;
        step();
        chk("t5 ls_gnt", {31'd0, ls_gnt}, 32'd1);
        ls_req = 0;
        cnt = 0;
        for (int i = 0; i < 20 && !ls_rvalid; i++) begin
            step();
            cnt++;
        end
        chk("t5 cycles", cnt, 8);
        chk("t5 err_o", {31'd0, err_o}, 32'd1);
        chk("t5 mem_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("t5 err pulse", {31'd0, err_o}, 32'd0);
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            if (if_gnt || !if_req) begin
                if_req = ($urandom_range(1) == 1);
                if_addr = $urandom;
            end else if ($urandom_range(19) == 0) if_req = 0;
            if (ls_gnt || !ls_req) begin
                ls_req = ($urandom_range(2) != 0);
                ls_we = $urandom_range(1) == 1;
                ls_addr = $urandom;
                ls_wdata = $urandom;
            end else if ($urandom_range(19) == 0) ls_req = 0;
            mem_ready = mem_req ? ($urandom_range(9) < (TO_EN ? 3 : 5)) : ($urandom_range(3) == 0);
            mem_rdata = $urandom;
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
